mem_stall_ctrl: RTL and testbench
=================================

# mem_stall_ctrl

Parametrised pipeline stall controller for the LC-3b pipeline. It tracks outstanding memory accesses on `NUM_CH` independent channels (by default channel 0 is the instruction cache and channel 1 the data cache) and raises `enable` only in the cycle every active channel has resolved. Multi-access operations such as LDI/STI are handled by a per-instruction phase counter on one designated channel. The block sits between the cache response signals and the pipeline-register load enables, and also exposes a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- `NUM_CH`, default 2: number of memory channels; must be at least 1.
- `DATA_CH`, default 1: index of the channel that supports multi-phase accesses; must be below `NUM_CH`.
- `PH_W`, default 2: width of the phase-count input and the `phase` output.
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req`  in  NUM_CH  per channel, high when the current stage has an access outstanding; held stable until `enable` is sampled high.
- `resp`  in  NUM_CH  per channel, single-cycle response pulse from the cache.
- `nphase`  in  PH_W  number of `DATA_CH` responses the current instruction needs; 0 is treated as 1; held stable with `req`.
- `enable`  out  1  pipeline advance; combinational.
- `phase`  out  PH_W  index of the current `DATA_CH` access; drives the indirect-address mux.
- `done`  out  NUM_CH  sticky per-channel resolved flags.
- `stall_cycles`  out  CNT_W  saturating count of cycles with `enable` low.
- `err`  out  1  sticky protocol-error flag.

## Operation
- Per-channel `ok[i]` is high when any of the following holds: `~req[i]`, `done[i]`, or `resp[i]` on a final access.
- A `resp` on a non-`DATA_CH` channel is always a final access.
- A `resp` on `DATA_CH` is final only when `phase == max(nphase,1)-1`.
- `enable = &ok`. It is fully combinational, so hits on all channels in the same cycle give zero stall.
- On a clock edge with `enable` high:
  - all `done` flags clear;
  - `phase` clears to 0.
  - This is the "ready" reset for the next instruction and takes priority over every other update.
- On a clock edge with `enable` low:
  - any final `resp[i]` with `req[i]` set sets `done[i]`;
  - a non-final `DATA_CH` `resp` increments `phase` and does not set `done`.
- Ignored responses, each of which also sets `err`:
  - `resp[i]` while `req[i]` is low;
  - `resp[i]` while `done[i]` is already set.
- `err` clears only on reset.
- `stall_cycles` increments on each edge where `enable` is low and any `req` is high; it saturates at all-ones and does not wrap.
- Per-channel flag state machine:
  - IDLE (`done=0`) goes to RESOLVED on a final `resp` with `enable` low;
  - RESOLVED goes back to IDLE on `enable`;
  - a final `resp` in IDLE with `enable` high stays in IDLE.
- `DATA_CH` phase sequence: it runs 0 to `nphase-1`, then resolves. `phase` never exceeds `max(nphase,1)-1`.

## Timing
- Reset values: `done=0`, `phase=0`, `stall_cycles=0`, `err=0`.
- During reset, `enable` still evaluates as `&(~req | resp)` with cleared flags.
- Reset asserted mid-stall abandons all progress. After release, every channel must see its responses again.
- `enable` is high for exactly one cycle per stalled instruction, unless the next instruction also resolves immediately.
- `phase` updates one edge after a non-final `DATA_CH` response, so the next address is available the following cycle.
- When channels respond in different cycles, `enable` rises in the cycle of the last response and not before.
- When no `req` is active, `enable` stays at 1 and all counters hold.

## Structure
- The shared `lc3b_types` package gains:
  - `typedef logic [PH_W-1:0] lc3b_phase`;
  - constants `CH_INSTR=0` and `CH_DATA=1`.
- The natural sub-module is `stall_channel`: one sticky flag with its `ok` and error logic. It is instantiated `NUM_CH` times through a generate loop.
- The phase counter, the stall counter and the final `enable` AND live in `mem_stall_ctrl`.

## Test plan
- **Both channels hit:** `req=2'b11`, `resp=2'b11` in cycle 0 → `enable=1` in cycle 0; `done` remains `00`; `stall_cycles=0`.
- **Split responses:** `req=11`; `resp[0]` at cycle 0; `resp[1]` at cycle 3 → `enable` low in cycles 0–2 and high in cycle 3; `done=01` during cycles 1–3; `stall_cycles=3`.
- **LDI, two phases:** `nphase=2`, `req=10`; `resp[1]` at cycles 1 and 4 → `phase` becomes 1 from cycle 2; `enable` only in cycle 4; `phase` returns to 0 after that edge.
- **Idle pipeline:** `req=00` for 10 cycles → `enable=1` throughout; `stall_cycles` unchanged.
- **Reset mid-stall:** `done=01` and `phase=1`, then pulse `rst_n` low asynchronously mid-cycle → outputs clear immediately; the full response sequence is required again.
- **Saturation and protocol error:** with `CNT_W=3`, stall 10 cycles → `stall_cycles=7`. Then `resp[0]` with `req[0]=0` → `err=1`, which stays set until reset.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: phase index, default channel assignment and
// the per-channel resolved-flag state encoding.
package lc3b_types;

    localparam int PHASE_W = 2;
    typedef logic [PHASE_W-1:0] lc3b_phase;

    localparam int CH_INSTR = 0;
    localparam int CH_DATA  = 1;

    typedef enum logic {
        CH_IDLE     = 1'b0,
        CH_RESOLVED = 1'b1
    } ch_state_e;

endpackage

// File: rtl/stall_channel.sv
// One memory channel's sticky resolved flag, its combinational ok term and
// the detection of responses that arrive when nothing is waiting for them.
module stall_channel
    import lc3b_types::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic resp,
    input  logic last,
    input  logic enable,
    output logic ok,
    output logic done,
    output logic bad_resp
);

    ch_state_e state_q, state_d;
    logic      resp_final;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        resp_final = resp & last;
        state_d    = state_q;
        if (enable) begin
            state_d = CH_IDLE;
        end else if (resp_final && req) begin
            state_d = CH_RESOLVED;
        end
    end

    assign done     = (state_q == CH_RESOLVED);
    assign ok       = ~req | done | resp_final;
    assign bad_resp = resp & (~req | done);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/mem_stall_ctrl.sv
// Pipeline stall controller: ANDs per-channel resolution into a combinational
// enable, sequences multi-access operations on DATA_CH and counts stall cycles.
module mem_stall_ctrl
    import lc3b_types::*;
#(
    parameter int NUM_CH  = 2,
    parameter int DATA_CH = CH_DATA,
    parameter int PH_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] resp,
    input  logic [PH_W-1:0]   nphase,
    output logic              enable,
    output logic [PH_W-1:0]   phase,
    output logic [NUM_CH-1:0] done,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic              err
);

    logic [NUM_CH-1:0] ok;
    logic [NUM_CH-1:0] last;
    logic [NUM_CH-1:0] bad_resp;
    logic [PH_W-1:0]   last_phase;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              err_q, err_d;

    // A zero phase count means a single access, so its last index is also 0.
    always_comb begin
        last_phase = (nphase == '0) ? '0 : nphase - PH_W'(1);
        for (int i = 0; i < NUM_CH; i++) begin
            last[i] = (i != DATA_CH) || (phase_q == last_phase);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        stall_channel u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .req      (req[i]),
            .resp     (resp[i]),
            .last     (last[i]),
            .enable   (enable),
            .ok       (ok[i]),
            .done     (done[i]),
            .bad_resp (bad_resp[i])
        );
    end

    assign enable = &ok;

    always_comb begin
        phase_d = phase_q;
        stall_d = stall_q;
        err_d   = err_q | (|bad_resp);
        if (enable) begin
            phase_d = '0;
        end else if (req[DATA_CH] && resp[DATA_CH] && !done[DATA_CH] && !last[DATA_CH]) begin
            phase_d = phase_q + PH_W'(1);
        end
        if (!enable && (|req) && !(&stall_q)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign phase        = phase_q;
    assign stall_cycles = stall_q;
    assign err          = err_q;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Scoreboard bench for mem_stall_ctrl (CNT_W=3 so saturation is reachable):
// the driver queues hand-computed expectations, a negedge monitor compares.
module tb_mem_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] resp;
    logic [1:0] nphase;
    logic       enable;
    logic [1:0] phase;
    logic [1:0] done;
    logic [2:0] stall_cycles;
    logic       err;

    mem_stall_ctrl #(
        .NUM_CH  (2),
        .DATA_CH (1),
        .PH_W    (2),
        .CNT_W   (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .resp         (resp),
        .nphase       (nphase),
        .enable       (enable),
        .phase        (phase),
        .done         (done),
        .stall_cycles (stall_cycles),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       en;
        logic [1:0] dn;
        logic [1:0] ph;
        logic [2:0] st;
        logic       er;
    } exp_t;

    exp_t       sb[$];
    int         vectors     = 0;
    int         miscompares = 0;
    logic [2:0] stall_m;

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (enable !== e.en || done !== e.dn || phase !== e.ph ||
                stall_cycles !== e.st || err !== e.er) begin
                miscompares++;
                $display("FAIL %s: got en=%b done=%b phase=%0d stall=%0d err=%b, expected en=%b done=%b phase=%0d stall=%0d err=%b",
                         e.name, enable, done, phase, stall_cycles, err,
                         e.en, e.dn, e.ph, e.st, e.er);
            end
        end
    end

    task automatic push(input string name, input logic en, input logic [1:0] dn,
                        input logic [1:0] ph, input logic er);
        exp_t e;
        e.name = name;
        e.en   = en;
        e.dn   = dn;
        e.ph   = ph;
        e.st   = stall_m;
        e.er   = er;
        sb.push_back(e);
    endtask

    // Drive one cycle, queue its expectation, then advance past the edge.
    task automatic step(input string name, input logic [1:0] rq, input logic [1:0] rs,
                        input logic [1:0] nph, input logic en, input logic [1:0] dn,
                        input logic [1:0] ph, input logic er);
        req    = rq;
        resp   = rs;
        nphase = nph;
        push(name, en, dn, ph, er);
        if (!en && rq != 2'b00 && stall_m != 3'd7) stall_m++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 2'b11;
        resp    = 2'b01;
        nphase  = 2'd0;
        stall_m = 3'd0;
        @(posedge clk);
        #1;
        // enable still evaluates combinationally while reset is held
        push("rst_hold_stall", 1'b0, 2'b00, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        resp = 2'b11;
        push("rst_hold_hit", 1'b1, 2'b00, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        step("both_hit", 2'b11, 2'b11, 2'd0, 1'b1, 2'b00, 2'd0, 1'b0);

        step("split_c0", 2'b11, 2'b01, 2'd0, 1'b0, 2'b00, 2'd0, 1'b0);
        step("split_c1", 2'b11, 2'b00, 2'd0, 1'b0, 2'b01, 2'd0, 1'b0);
        step("split_c2", 2'b11, 2'b00, 2'd0, 1'b0, 2'b01, 2'd0, 1'b0);
        step("split_c3", 2'b11, 2'b10, 2'd0, 1'b1, 2'b01, 2'd0, 1'b0);
        step("split_clr", 2'b00, 2'b00, 2'd0, 1'b1, 2'b00, 2'd0, 1'b0);

        step("ldi_c0", 2'b10, 2'b00, 2'd2, 1'b0, 2'b00, 2'd0, 1'b0);
        step("ldi_c1", 2'b10, 2'b10, 2'd2, 1'b0, 2'b00, 2'd0, 1'b0);
        step("ldi_c2", 2'b10, 2'b00, 2'd2, 1'b0, 2'b00, 2'd1, 1'b0);
        step("ldi_c3", 2'b10, 2'b00, 2'd2, 1'b0, 2'b00, 2'd1, 1'b0);
        step("ldi_c4", 2'b10, 2'b10, 2'd2, 1'b1, 2'b00, 2'd1, 1'b0);
        step("ldi_clr", 2'b00, 2'b00, 2'd0, 1'b1, 2'b00, 2'd0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            step("idle", 2'b00, 2'b00, 2'd0, 1'b1, 2'b00, 2'd0, 1'b0);
        end

        step("mid_c0", 2'b11, 2'b10, 2'd2, 1'b0, 2'b00, 2'd0, 1'b0);
        step("mid_c1", 2'b11, 2'b01, 2'd2, 1'b0, 2'b00, 2'd1, 1'b0);
        step("mid_c2", 2'b11, 2'b00, 2'd2, 1'b0, 2'b01, 2'd1, 1'b0);

        // Asynchronous reset pulse in the middle of a stall cycle.
        req  = 2'b11;
        resp = 2'b00;
        #2;
        rst_n   = 1'b0;
        stall_m = 3'd0;
        push("rst_mid", 1'b0, 2'b00, 2'd0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        stall_m = 3'd1;

        step("redo_c0", 2'b11, 2'b01, 2'd2, 1'b0, 2'b00, 2'd0, 1'b0);
        step("redo_c1", 2'b11, 2'b10, 2'd2, 1'b0, 2'b01, 2'd0, 1'b0);
        step("redo_c2", 2'b11, 2'b10, 2'd2, 1'b1, 2'b01, 2'd1, 1'b0);
        step("redo_clr", 2'b00, 2'b00, 2'd0, 1'b1, 2'b00, 2'd0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            step("sat_stall", 2'b01, 2'b00, 2'd0, 1'b0, 2'b00, 2'd0, 1'b0);
        end
        step("sat_end", 2'b01, 2'b01, 2'd0, 1'b1, 2'b00, 2'd0, 1'b0);

        step("err_c0", 2'b00, 2'b01, 2'd0, 1'b1, 2'b00, 2'd0, 1'b0);
        step("err_c1", 2'b00, 2'b00, 2'd0, 1'b1, 2'b00, 2'd0, 1'b1);
        step("err_c2", 2'b11, 2'b11, 2'd0, 1'b1, 2'b00, 2'd0, 1'b1);

        req  = 2'b11;
        resp = 2'b11;
        #2;
        rst_n   = 1'b0;
        stall_m = 3'd0;
        push("rst_err", 1'b1, 2'b00, 2'd0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        step("dup_c0", 2'b11, 2'b01, 2'd0, 1'b0, 2'b00, 2'd0, 1'b0);
        step("dup_c1", 2'b11, 2'b01, 2'd0, 1'b0, 2'b01, 2'd0, 1'b0);
        step("dup_c2", 2'b11, 2'b00, 2'd0, 1'b0, 2'b01, 2'd0, 1'b1);
        step("dup_c3", 2'b11, 2'b10, 2'd0, 1'b1, 2'b01, 2'd0, 1'b1);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked expectations, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
